riscv_issue_ctrl: RTL

Dual-issue scheduler between decode and the two execute pipes of the superscalar core. Each cycle it takes up to two decoded instructions (slot0 older, slot1 younger), checks pairing rules and a load-result scoreboard, and registers them into pipe0 (full: ALU, branch, load/store, system) and pipe1 (ALU only). It also applies execute hold, flushes on a branch redirect from pipe0, and reports to decode how many instructions were consumed.

---
 rtl/riscv_issue_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/riscv_issue_ctrl.sv
// riscv_issue_ctrl -- dual-issue scheduler between decode and the two execute pipes.
//
// Takes up to two decoded instructions per cycle (slot0 older, slot1 younger),
// applies the pairing rules and a load-result scoreboard, and registers the
// accepted instructions into pipe0 (full) and pipe1 (ALU only).
//
// Build option: define RISCV_DUAL_ISSUE_EN to enable pairing into pipe1.
// Without it the core is single-issue: take never reads 2'b11 and the exec1
// outputs stay at 0.
//
// Ports
//   clk, rst_n                   core clock, async active-low reset
//   slot0_*/slot1_*              decoded instruction: valid, instr, pc, rd/ra/rb
//   take                         consume count to decode (00 none, 01 slot0, 11 both)
//   exec0_*/exec1_*              registered issue: valid, instr, pc, rd/ra/rb
//   hold                         execute/memory stall
//   br_d_req                     branch redirect from pipe0
//   wb_valid, wb_rd              load writeback, clears the scoreboard bit
//
// state | meaning
// RUN   | normal issue
// STALL | slot0 blocked by a pending load result; leaves in the cycle the bits clear
// FLUSH | single bubble while decode re-fetches after a redirect
module riscv_issue_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        slot0_valid,
  input  logic [31:0] slot0_instr,
  input  logic [31:0] slot0_pc,
  input  logic [4:0]  slot0_rd,
  input  logic [4:0]  slot0_ra,
  input  logic [4:0]  slot0_rb,
  input  logic        slot1_valid,
  input  logic [31:0] slot1_instr,
  input  logic [31:0] slot1_pc,
  input  logic [4:0]  slot1_rd,
  input  logic [4:0]  slot1_ra,
  input  logic [4:0]  slot1_rb,
  input  logic        hold,
  input  logic        br_d_req,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  output logic [1:0]  take,
  output logic        exec0_valid,
  output logic [31:0] exec0_instr,
  output logic [31:0] exec0_pc,
  output logic [4:0]  exec0_rd,
  output logic [4:0]  exec0_ra,
  output logic [4:0]  exec0_rb,
  output logic        exec1_valid,
  output logic [31:0] exec1_instr,
  output logic [31:0] exec1_pc,
  output logic [4:0]  exec1_rd,
  output logic [4:0]  exec1_ra,
  output logic [4:0]  exec1_rb
);

  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2} state_t;
  typedef enum logic [2:0] {CL_ALU, CL_BR, CL_LD, CL_ST, CL_SYS} cls_t;

  function automatic cls_t op_class(input logic [6:0] op);
    case (op)
      7'b1100011, 7'b1101111, 7'b1100111: op_class = CL_BR;
      7'b0000011:                         op_class = CL_LD;
      7'b0100011:                         op_class = CL_ST;
      7'b1110011:                         op_class = CL_SYS;
      default:                            op_class = CL_ALU;
    endcase
  endfunction

  state_t      state;
  logic [31:0] pending;
  logic [31:0] wb_clr;
  logic [31:0] pend_eff;
  logic [31:0] ld_set;
  logic [31:0] pend_nxt;
  cls_t        cls0;
  logic        blk0;
  logic        iss0;
  logic        pair;
  logic        go;

  // A writeback in the current cycle already counts as clear, so a stalled
  // consumer issues in the same cycle its load result arrives.
  always_comb begin
    wb_clr = '0;
    if (wb_valid) wb_clr[wb_rd] = 1'b1;
    pend_eff = pending & ~wb_clr;
    cls0     = op_class(slot0_instr[6:0]);
    blk0     = pend_eff[slot0_ra] | pend_eff[slot0_rb] | pend_eff[slot0_rd];
    iss0     = slot0_valid & ~blk0;
  end

`ifdef RISCV_DUAL_ISSUE_EN
  logic blk1;
  logic raw01;
  always_comb begin
    blk1  = pend_eff[slot1_ra] | pend_eff[slot1_rb] | pend_eff[slot1_rd];
    raw01 = (slot0_rd != 5'd0) &&
            (slot0_rd == slot1_ra || slot0_rd == slot1_rb || slot0_rd == slot1_rd);
    pair  = iss0 && slot1_valid && (op_class(slot1_instr[6:0]) == CL_ALU) &&
            (cls0 != CL_BR) && (cls0 != CL_SYS) && !raw01 && !blk1;
  end
`else
  logic unused_slot1;
  assign pair         = 1'b0;
  assign unused_slot1 = slot1_valid;
`endif

  // STALL needs no explicit gate here: while slot0 is blocked iss0 is already 0.
  assign go = rst_n && !hold && !br_d_req && (state != FLUSH);

  always_comb begin
    take = 2'b00;
    if (go) begin
      if (pair)      take = 2'b11;
      else if (iss0) take = 2'b01;
    end
  end

  // Set beats clear on the same index; x0 never goes pending.
  always_comb begin
    ld_set = '0;
    if (take[0] && cls0 == CL_LD) ld_set[slot0_rd] = 1'b1;
    pend_nxt = ((pending & ~wb_clr) | ld_set) & ~32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      pending     <= '0;
      exec0_valid <= 1'b0;
      exec0_instr <= '0;
      exec0_pc    <= '0;
      exec0_rd    <= '0;
      exec0_ra    <= '0;
      exec0_rb    <= '0;
      exec1_valid <= 1'b0;
      exec1_instr <= '0;
      exec1_pc    <= '0;
      exec1_rd    <= '0;
      exec1_ra    <= '0;
      exec1_rb    <= '0;
    end else begin
      pending <= pend_nxt;
      if (br_d_req) begin
        state       <= FLUSH;
        exec0_valid <= 1'b0;
        exec1_valid <= 1'b0;
      end else begin
        case (state)
          RUN:     if (slot0_valid && blk0) state <= STALL;
          STALL:   if (!(slot0_valid && blk0)) state <= RUN;
          default: state <= RUN;
        endcase
        if (!hold) begin
          exec0_valid <= take[0];
          exec1_valid <= take[1];
          if (take[0]) begin
            exec0_instr <= slot0_instr;
            exec0_pc    <= slot0_pc;
            exec0_rd    <= slot0_rd;
            exec0_ra    <= slot0_ra;
            exec0_rb    <= slot0_rb;
          end
          if (take[1]) begin
            exec1_instr <= slot1_instr;
            exec1_pc    <= slot1_pc;
            exec1_rd    <= slot1_rd;
            exec1_ra    <= slot1_ra;
            exec1_rb    <= slot1_rb;
          end
        end
      end
    end
  end

endmodule
